gray_fifo_ctrl: RTL

- Single-clock FIFO pointer controller; drives an external dual-port RAM (write and read address/enable) and produces full, empty, almost-full and level status.
- Pointers are held as registered Gray codes (ADDR_WIDTH+1 bits, with a wrap bit) and converted to binary through gray2bin instances.
- The Gray pointers are exported directly, so a later dual-clock FIFO can synchronise them without re-encoding.

---
 rtl/gray_fifo_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gray_fifo_ctrl.sv
// gray_fifo_ctrl: single-clock FIFO pointer controller for an external dual-port RAM.
// Both pointers live as (ADDR_WIDTH+1)-bit Gray codes, with the extra bit as the wrap
// bit. They are exported unchanged so that a dual-clock variant can synchronise them
// directly.
// Optional build macro GRAY_FIFO_CTRL_ERR_EN adds sticky overflow/underflow flags
// (ovf_o, udf_o).

// gray2bin: each binary bit is the XOR of its Gray bit and every more-significant Gray bit.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Prefix-XOR from the MSB down, one reduction per output bit.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

module gray_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH-1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   level_o
`ifdef GRAY_FIFO_CTRL_ERR_EN
  ,
  output logic                  ovf_o,
  output logic                  udf_o
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  // In Gray code, "full" means the write pointer equals the read pointer with its top
  // two bits inverted. This mask holds exactly those two bits.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
  localparam logic [PW-1:0] AF_LVL    = PW'(AF_LEVEL);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] wr_bin, rd_bin;
  logic          push_ok, pop_ok;

  gray2bin #(.W(PW)) u_wr_g2b (.gray_i(wr_gray_q), .bin_o(wr_bin));
  gray2bin #(.W(PW)) u_rd_g2b (.gray_i(rd_gray_q), .bin_o(rd_bin));

  // All status is decoded from the registered pointers only, never from push_i or pop_i.
  assign empty_o       = (wr_gray_q == rd_gray_q);
  assign full_o        = (wr_gray_q == (rd_gray_q ^ FULL_MASK));
  assign level_o       = wr_bin - rd_bin;
  assign almost_full_o = (level_o >= AF_LVL);

  assign push_ok = push_i & ~full_o  & ~flush_i;
  assign pop_ok  = pop_i  & ~empty_o & ~flush_i;

  assign wr_en_o       = push_ok;
  assign rd_en_o       = pop_ok;
  assign wr_addr_o     = wr_bin[ADDR_WIDTH-1:0];
  assign rd_addr_o     = rd_bin[ADDR_WIDTH-1:0];
  assign wr_ptr_gray_o = wr_gray_q;
  assign rd_ptr_gray_o = rd_gray_q;

  // Next pointers: a flush zeroes both pointers and wins over any accepted request.
  // Otherwise an accepted request advances its pointer by one binary step, re-encoded to Gray.
  always_comb begin
    wr_gray_d = wr_gray_q;
    rd_gray_d = rd_gray_q;
    if (flush_i) begin
      wr_gray_d = '0;
      rd_gray_d = '0;
    end else begin
      if (push_ok) wr_gray_d = bin2gray(wr_bin + PW'(1));
      if (pop_ok)  rd_gray_d = bin2gray(rd_bin + PW'(1));
    end
  end

  // Pointer registers; the synchronous reset discards any update computed this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_gray_q <= '0;
      rd_gray_q <= '0;
    end else begin
      wr_gray_q <= wr_gray_d;
      rd_gray_q <= rd_gray_d;
    end
  end

`ifdef GRAY_FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags: a rejected push or pop sets its flag; only reset or flush clears it.
  always_comb begin
    ovf_d = ovf_q | (push_i & full_o);
    udf_d = udf_q | (pop_i & empty_o);
    if (flush_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  // No error flags in this build: a rejected push or pop is silently dropped.
`endif

endmodule
